// File: rtl/uart_rx_param_if.sv
// Receive-side word stream: the receiver presents a word with its error flags and
// holds it until the consumer takes it with valid && ready.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 ready;
    logic                 framing_error;
    logic                 parity_error;
    logic                 overrun;

    modport master (
        output data_out,
        output valid,
        output framing_error,
        output parity_error,
        output overrun,
        input  ready
    );

    modport slave (
        input  data_out,
        input  valid,
        input  framing_error,
        input  parity_error,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority voting, configurable frame format and a
// valid/ready output. Parity checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int DATA_BITS       = 8,
    parameter int STOP_BITS       = 1,
    parameter int OVERSAMPLE      = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            data_in,
    input  logic [31:0]     baud_rate,
    input  logic [1:0]      parity_mode,
    output logic            busy,
    uart_rx_param_if.master rx_if
);
    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_S0   = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_S1   = IDX_W'(OVERSAMPLE / 2);
    localparam logic [IDX_W-1:0] IDX_S2   = IDX_W'(OVERSAMPLE / 2 + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_LINE_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, rx_prev_q;
    logic [31:0]          div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [1:0]           vote_q, vote_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;

    logic        rx;
    logic [31:0] rate_x, div_raw, divisor;
    logic        tick, sample_tick, end_tick, maj, stop_fail, complete;
    logic        par_used, par_err;

    assign rx = sync2_q;

    // Divisor 0 would never tick, so it is clamped; a zero rate is treated as the slowest line.
    assign rate_x  = baud_rate * 32'(OVERSAMPLE);
    assign div_raw = (rate_x == 32'd0) ? 32'hFFFF_FFFF : 32'(CLOCK_FREQUENCY) / rate_x;
    assign divisor = (div_raw == 32'd0) ? 32'd1 : div_raw;

    assign tick        = (div_cnt_q >= divisor - 32'd1);
    assign sample_tick = tick && (idx_q == IDX_S2);
    assign end_tick    = tick && (idx_q == IDX_LAST);
    assign maj         = (({1'b0, vote_q} + {2'b00, rx}) >= 3'd2);
    assign stop_fail   = ferr_acc_q | ~maj;

`ifdef UART_RX_PARITY_EN
    logic [1:0] par_mode_q, par_mode_d;
    logic       par_bit_q, par_bit_d;
    logic       frame_xor;

    assign frame_xor = (^shift_q) ^ par_bit_q;
    assign par_used  = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
    assign par_err   = ((par_mode_q == 2'b01) && frame_xor) ||
                       ((par_mode_q == 2'b10) && !frame_xor);
`else
    logic unused_parity_mode;

    assign unused_parity_mode = ^parity_mode;
    assign par_used           = 1'b0;
    assign par_err            = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        idx_d      = idx_q;
        vote_d     = vote_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        ferr_acc_d = ferr_acc_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        overrun_d  = 1'b0;
        complete   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_mode_d = par_mode_q;
        par_bit_d  = par_bit_q;
`endif

        if (state_q == S_IDLE) begin
            div_cnt_d = 32'd0;
            idx_d     = '0;
        end else if (tick) begin
            div_cnt_d = 32'd0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            div_cnt_d = div_cnt_q + 32'd1;
        end

        if (tick && (idx_q == IDX_S0)) begin
            vote_d = {1'b0, rx};
        end else if (tick && (idx_q == IDX_S1)) begin
            vote_d = vote_q + {1'b0, rx};
        end

        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx) begin
                    state_d    = S_START;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_mode_d = parity_mode;
`endif
                end
            end
            S_START: begin
                if (sample_tick && maj) begin
                    state_d = S_IDLE;
                end else if (end_tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (sample_tick) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                end
                if (end_tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = par_used ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample_tick) begin
                    par_bit_d = maj;
                end
                if (end_tick) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // The last stop bit completes at mid-bit to leave margin for the next start edge.
                if (sample_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        complete = 1'b1;
                        state_d  = maj ? S_IDLE : S_LINE_WAIT;
                    end else begin
                        ferr_acc_d = stop_fail;
                    end
                end
                if (end_tick) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            S_LINE_WAIT: begin
                if (rx) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A handshake in the same cycle frees the slot, so the new word loads instead of overrunning.
        if (complete) begin
            if (!valid_q || rx_if.ready) begin
                data_out_d = shift_q;
                ferr_d     = stop_fail;
                perr_d     = par_used && par_err;
                valid_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_if.ready) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            div_cnt_q  <= 32'd0;
            idx_q      <= '0;
            vote_q     <= 2'd0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            shift_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_mode_q <= 2'b00;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= data_in;
            sync2_q    <= sync1_q;
            rx_prev_q  <= sync2_q;
            div_cnt_q  <= div_cnt_d;
            idx_q      <= idx_d;
            vote_q     <= vote_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            ferr_acc_q <= ferr_acc_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_mode_q <= par_mode_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign rx_if.data_out      = data_out_q;
    assign rx_if.valid         = valid_q;
    assign rx_if.framing_error = ferr_q;
    assign rx_if.parity_error  = perr_q;
    assign rx_if.overrun       = overrun_q;
    assign busy                = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: frames are built from a frame-level model,
// expected words are queued at issue and popped by a monitor at each handshake.
module tb_uart_rx_param;
    localparam int CLK_HZ     = 100000000;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 2;
    localparam int OVERSAMPLE = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } word_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        data_in;
    logic [31:0] baud_rate;
    logic [1:0]  parity_mode;
    logic        busy;
    logic        ready_fixed;
    logic        rand_ready_en;
    logic        rand_ready = 1'b1;

    int    tests_run    = 0;
    int    tests_failed = 0;
    int    overrun_seen = 0;
    int    bit_clks     = 64;
    bit    prev_hs      = 1'b0;
    word_t exp_q[$];
    word_t mon_word;
    int unsigned baud_tab [4] = '{32'd3125000, 32'd1562500, 32'd1000000, 32'd10000000};

    uart_rx_param_if #(.DATA_BITS(DATA_BITS)) rx_if ();

    assign rx_if.ready = rand_ready_en ? rand_ready : ready_fixed;

    uart_rx_param #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .DATA_BITS      (DATA_BITS),
        .STOP_BITS      (STOP_BITS),
        .OVERSAMPLE     (OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .baud_rate  (baud_rate),
        .parity_mode(parity_mode),
        .busy       (busy),
        .rx_if      (rx_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rand_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int unsigned divisorFor(input int unsigned baud);
        int unsigned prod;
        int unsigned d;
        prod = baud * OVERSAMPLE;
        d = (prod == 0) ? 32'hFFFF_FFFF : 32'(CLK_HZ) / prod;
        return (d == 0) ? 1 : d;
    endfunction

    function automatic bit parityUsed(input logic [1:0] mode);
        bit en;
`ifdef UART_RX_PARITY_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && ((mode == 2'b01) || (mode == 2'b10));
    endfunction

    task automatic setBaud(input int unsigned baud);
        baud_rate = baud;
        bit_clks  = int'(divisorFor(baud)) * OVERSAMPLE;
    endtask

    task automatic driveBit(input bit b);
        data_in = b;
        repeat (bit_clks) @(posedge clk);
        #1;
    endtask

    task automatic idleLine(input int n);
        data_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame = start, data LSB first, optional parity bit, two stop bits.
    task automatic applyStimulus(input logic [7:0] data, input logic [1:0] mode, input bit pbit,
                                 input bit stop0, input bit stop1, input bit deliver);
        word_t w;
        int    ones;
        ones   = $countones(data) + int'(pbit);
        w.data = data;
        w.fe   = !(stop0 && stop1);
        w.pe   = parityUsed(mode) && ((ones % 2) != ((mode == 2'b10) ? 1 : 0));
        if (deliver) exp_q.push_back(w);
        parity_mode = mode;
        driveBit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) driveBit(data[i]);
        if (parityUsed(mode)) driveBit(pbit);
        driveBit(stop0);
        driveBit(stop1);
    endtask

    task automatic waitDrain(input int max_cycles);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < max_cycles) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) checkOutput("valid_after_accept", 32'(rx_if.valid), 32'd0);
            if (rx_if.overrun) overrun_seen++;
            if (rx_if.valid && rx_if.ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", rx_if.data_out);
                end else begin
                    mon_word = exp_q.pop_front();
                    checkOutput("word_data", 32'(rx_if.data_out), 32'(mon_word.data));
                    checkOutput("word_framing", 32'(rx_if.framing_error), 32'(mon_word.fe));
                    checkOutput("word_parity", 32'(rx_if.parity_error), 32'(mon_word.pe));
                end
            end
            prev_hs = rx_if.valid && rx_if.ready;
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("[TB] FAIL watchdog: got cycle limit, expected test end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        data_in       = 1'b1;
        parity_mode   = 2'b00;
        ready_fixed   = 1'b1;
        rand_ready_en = 1'b0;
        setBaud(1562500);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset_data", 32'(rx_if.data_out), 32'd0);
        checkOutput("reset_valid", 32'(rx_if.valid), 32'd0);
        checkOutput("reset_framing", 32'(rx_if.framing_error), 32'd0);
        checkOutput("reset_parity", 32'(rx_if.parity_error), 32'd0);
        checkOutput("reset_overrun", 32'(rx_if.overrun), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        idleLine(20);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        setBaud(115200);
        checkOutput("divisor_115200", 32'(bit_clks), 32'd864);
        applyStimulus(8'hA5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        waitDrain(2000);

        setBaud(1562500);
        idleLine(10);
        applyStimulus(8'h3C, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
        idleLine(10);
        applyStimulus(8'h3C, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
        waitDrain(200);
        applyStimulus(8'hC7, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
        waitDrain(200);

        applyStimulus(8'h96, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        data_in = 1'b0;
        repeat (10 * bit_clks) @(posedge clk);
        #1;
        checkOutput("linewait_busy_mid", 32'(busy), 32'd1);
        repeat (10 * bit_clks) @(posedge clk);
        #1;
        checkOutput("linewait_busy_end", 32'(busy), 32'd1);
        checkOutput("linewait_no_new_valid", 32'(rx_if.valid), 32'd0);
        idleLine(8);
        checkOutput("linewait_exit_busy", 32'(busy), 32'd0);
        waitDrain(50);

        data_in = 1'b0;
        repeat (3 * int'(divisorFor(1562500))) @(posedge clk);
        #1;
        checkOutput("glitch_busy_rise", 32'(busy), 32'd1);
        idleLine(bit_clks);
        checkOutput("glitch_busy_fall", 32'(busy), 32'd0);
        checkOutput("glitch_no_valid", 32'(rx_if.valid), 32'd0);

        ready_fixed = 1'b0;
        applyStimulus(8'h11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        idleLine(10);
        applyStimulus(8'h22, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        idleLine(4);
        checkOutput("overrun_pulses", 32'(overrun_seen), 32'd1);
        checkOutput("overrun_held_valid", 32'(rx_if.valid), 32'd1);
        checkOutput("overrun_held_data", 32'(rx_if.data_out), 32'h11);
        ready_fixed = 1'b1;
        waitDrain(20);
        checkOutput("overrun_valid_fall", 32'(rx_if.valid), 32'd0);

        idleLine(10);
        parity_mode = 2'b00;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(i[0]);
        data_in = 1'b1;
        repeat (bit_clks / 2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        checkOutput("abort_data", 32'(rx_if.data_out), 32'd0);
        checkOutput("abort_valid", 32'(rx_if.valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_framing", 32'(rx_if.framing_error), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idleLine(20);
        applyStimulus(8'h5A, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        waitDrain(200);

        rand_ready_en = 1'b1;
        for (int n = 0; n < 16; n++) begin
            setBaud(baud_tab[$urandom_range(0, 3)]);
            idleLine($urandom_range(1, bit_clks));
            applyStimulus(8'($urandom), 2'($urandom), 1'($urandom),
                          ($urandom_range(0, 4) != 0), 1'b1, 1'b1);
            waitDrain(4 * bit_clks + 100);
        end
        rand_ready_en = 1'b0;
        idleLine(10);
        checkOutput("final_overrun_count", 32'(overrun_seen), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
